// File: rtl/pulse_gen_multi.sv
// Multi-channel edge-triggered pulse generator: optional synchroniser, selectable
// edge detect, programmable pulse length with retrigger, holdoff and sticky missed flags.

module pulse_gen_chan #(
  parameter int LEN_BITS  = 16,
  parameter int HOLD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 s,
  input  logic [1:0]           edge_mode,
  input  logic [LEN_BITS-1:0]  pulse_len,
  input  logic [HOLD_BITS-1:0] holdoff,
  input  logic                 retrigger,
  input  logic                 clear_missed,
  output logic                 pulse,
  output logic                 busy,
  output logic                 missed
);
  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;

  state_t               state, nxt;
  logic                 s_d;
  logic                 qual;
  logic                 drop;
  logic [LEN_BITS-1:0]  len_cnt;
  logic [LEN_BITS-1:0]  len_m1;
  logic [HOLD_BITS-1:0] hold_q;
  logic [HOLD_BITS-1:0] hold_cnt;

  always_comb begin
    qual = 1'b0;
    case (edge_mode)
      2'b00:   qual = s & ~s_d;
      2'b01:   qual = ~s & s_d;
      2'b10:   qual = s ^ s_d;
      default: qual = 1'b0;
    endcase
  end

  // A length of 0 behaves as 1, so the loaded count saturates at 0.
  assign len_m1 = (pulse_len == '0) ? '0 : pulse_len - LEN_BITS'(1);
  assign drop   = qual && ((state == ACTIVE && !retrigger) || state == HOLDOFF);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (qual) nxt = ACTIVE;
      ACTIVE:  if (!(qual && retrigger) && len_cnt == '0)
                 nxt = (hold_q == '0) ? IDLE : HOLDOFF;
      HOLDOFF: if (hold_cnt == '0) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_d      <= 1'b0;
      len_cnt  <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
      missed   <= 1'b0;
    end else begin
      s_d    <= s;
      // A drop in the same cycle as a clear leaves the flag set.
      missed <= drop | (missed & ~clear_missed);
      case (state)
        IDLE: if (qual) begin
          len_cnt <= len_m1;
          hold_q  <= holdoff;
        end
        ACTIVE: begin
          if (qual && retrigger) begin
            len_cnt <= len_m1;
            hold_q  <= holdoff;
          end else if (len_cnt != '0) begin
            len_cnt <= len_cnt - LEN_BITS'(1);
          end else begin
            hold_cnt <= hold_q - HOLD_BITS'(1);
          end
        end
        HOLDOFF: if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_BITS'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    pulse = (state == ACTIVE);
    busy  = (state != IDLE);
  end
endmodule

module pulse_gen_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LEN_BITS    = 16,
  parameter int HOLD_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CHANNELS-1:0]  trigger,
  input  logic [1:0]           edge_mode,
  input  logic [LEN_BITS-1:0]  pulse_len,
  input  logic [HOLD_BITS-1:0] holdoff,
  input  logic                 retrigger,
  input  logic                 clear_missed,
  output logic [CHANNELS-1:0]  pulse,
  output logic [CHANNELS-1:0]  busy,
  output logic [CHANNELS-1:0]  missed
);
  logic [CHANNELS-1:0] s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = trigger;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (!rstn) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= trigger;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign s = sync_q[SYNC_STAGES-1];
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
      pulse_gen_chan #(
        .LEN_BITS  (LEN_BITS),
        .HOLD_BITS (HOLD_BITS)
      ) u_chan (
        .clk          (clk),
        .rstn         (rstn),
        .s            (s[c]),
        .edge_mode    (edge_mode),
        .pulse_len    (pulse_len),
        .holdoff      (holdoff),
        .retrigger    (retrigger),
        .clear_missed (clear_missed),
        .pulse        (pulse[c]),
        .busy         (busy[c]),
        .missed       (missed[c])
      );
    end
  endgenerate
endmodule

// File: tb/tb_pulse_gen_multi.sv
// Drives an unsynchronised (SYNC_STAGES=0) and a synchronised (SYNC_STAGES=2) instance
// in parallel and compares both against a pulse-window timeline model.

module tb_pulse_gen_multi;
  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  trig;
  logic [1:0]  em;
  logic [15:0] len, hold;
  logic        ret, clr;
  logic [3:0]  pul [2];
  logic [3:0]  bsy [2];
  logic [3:0]  mss [2];

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Model: per instance/channel, the last edge index after which pulse/busy are high.
  int        ss [2] = '{0, 2};
  logic [3:0] hist [2][4];
  int        pend [2][4];
  int        hend [2][4];
  logic      mis  [2][4];

  always #5 clk = ~clk;

  pulse_gen_multi #(.CHANNELS(4), .SYNC_STAGES(0), .LEN_BITS(16), .HOLD_BITS(16)) u_dut0 (
    .clk(clk), .rstn(rstn), .trigger(trig), .edge_mode(em), .pulse_len(len),
    .holdoff(hold), .retrigger(ret), .clear_missed(clr),
    .pulse(pul[0]), .busy(bsy[0]), .missed(mss[0]));

  pulse_gen_multi #(.CHANNELS(4), .SYNC_STAGES(2), .LEN_BITS(16), .HOLD_BITS(16)) u_dut2 (
    .clk(clk), .rstn(rstn), .trigger(trig), .edge_mode(em), .pulse_len(len),
    .holdoff(hold), .retrigger(ret), .clear_missed(clr),
    .pulse(pul[1]), .busy(bsy[1]), .missed(mss[1]));

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        for (int k = 0; k < 4; k++) hist[d][k] = '0;
        for (int c = 0; c < 4; c++) begin
          pend[d][c] = -100;
          hend[d][c] = -100;
          mis[d][c]  = 1'b0;
        end
      end else begin
        for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = trig;
        for (int c = 0; c < 4; c++) begin
          logic s, sd, e, drop;
          int   l;
          s  = hist[d][ss[d]][c];
          sd = hist[d][ss[d]+1][c];
          case (em)
            2'd0:    e = s & ~sd;
            2'd1:    e = ~s & sd;
            2'd2:    e = s ^ sd;
            default: e = 1'b0;
          endcase
          l = (len == 0) ? 1 : int'(len);
          drop = 1'b0;
          if (e) begin
            if (hend[d][c] < n - 1 || (pend[d][c] >= n - 1 && ret)) begin
              pend[d][c] = n + l - 1;
              hend[d][c] = pend[d][c] + int'(hold);
            end else begin
              drop = 1'b1;
            end
          end
          mis[d][c] = drop ? 1'b1 : (clr ? 1'b0 : mis[d][c]);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [3:0] got, input logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s dut%0d cyc=%0d observed=%b expected=%b", tag, ss[d], n, got, exp);
    end
  endtask

  task automatic step();
    logic [3:0] ep, eb, emi;
    @(posedge clk);
    n++;
    model_step();
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 4; c++) begin
        ep[c]  = (pend[d][c] >= n);
        eb[c]  = (hend[d][c] >= n);
        emi[c] = mis[d][c];
      end
      chk("pulse",  d, pul[d], ep);
      chk("busy",   d, bsy[d], eb);
      chk("missed", d, mss[d], emi);
    end
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    rstn = 1'b0; trig = '0; em = 2'd0; len = 16'd1; hold = 16'd0; ret = 1'b0; clr = 1'b0;
    run(3);
    rstn = 1'b1;
    run(2);

    // Held trigger: single one-cycle pulse.
    trig = 4'b0001; run(10);
    trig = '0;      run(4);

    // len 5 / holdoff 3 on ch1 with a dropped second edge.
    len = 16'd5; hold = 16'd3;
    trig = 4'b0010; run(1); trig = '0; run(2);
    trig = 4'b0010; run(1); trig = '0; run(12);

    // Retrigger on ch2 stretches one continuous pulse.
    ret = 1'b1; len = 16'd4; hold = 16'd0;
    trig = 4'b0100; run(1); trig = '0; run(2);
    trig = 4'b0100; run(1); trig = '0; run(3);
    trig = 4'b0100; run(1); trig = '0; run(10);

    // Both edges, pulse_len 0, then detection disabled.
    ret = 1'b0; em = 2'd2; len = 16'd0;
    repeat (6) begin trig[3] = ~trig[3]; run(3); end
    em = 2'd3;
    repeat (4) begin trig[3] = ~trig[3]; run(3); end
    em = 2'd0; trig = '0; run(4);

    // Back-to-back toggling at holdoff 0 / len 1.
    em = 2'd2; len = 16'd1;
    repeat (8) begin trig = ~trig; run(1); end
    trig = '0; em = 2'd0; run(6);

    // Reset mid-pulse with trigger held across it.
    len = 16'd6; hold = 16'd2;
    trig = 4'b0001; run(3);
    rstn = 1'b0; run(1);
    rstn = 1'b1; run(14);
    trig = '0; run(10);

    // Dropped edges colliding with clear_missed, then a lone clear.
    em = 2'd2; len = 16'd8; hold = 16'd4;
    for (int i = 0; i < 16; i++) begin
      trig[0] = ~trig[0];
      clr = i[0];
      run(1);
    end
    clr = 1'b0; trig = '0; run(3);
    clr = 1'b1; run(1);
    clr = 1'b0; run(20);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        em   = 2'($urandom_range(0, 3));
        len  = 16'($urandom_range(0, 5));
        hold = 16'($urandom_range(0, 4));
        ret  = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 3) == 0) trig[c] = ~trig[c];
      clr  = ($urandom_range(0, 7) == 0);
      rstn = ($urandom_range(0, 99) != 0);
      run(1);
    end
    rstn = 1'b1; clr = 1'b0; trig = '0;
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
